// File: rtl/commit_tracker.sv
// Commit tracker: compacts up to NCH retiring instructions per cycle into a queue,
// drains one per cycle onto a registered commit port, and latches trap/watchdog status.
module commit_tracker #(
    parameter int XLEN    = 64,
    parameter int NCH     = 2,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*XLEN-1:0]  in_pc,
    input  logic [NCH*32-1:0]    in_inst,
    input  logic [NCH-1:0]       in_wen,
    input  logic [NCH*8-1:0]     in_wdest,
    input  logic [NCH*XLEN-1:0]  in_wdata,
    input  logic [7:0]           in_trap_code,
    output logic                 in_ready,
    output logic                 cmt_valid,
    output logic [XLEN-1:0]      cmt_pc,
    output logic [31:0]          cmt_inst,
    output logic                 cmt_wen,
    output logic [7:0]           cmt_wdest,
    output logic [XLEN-1:0]      cmt_wdata,
    output logic                 trap,
    output logic [7:0]           trap_code,
    output logic [XLEN-1:0]      trap_pc,
    output logic                 timeout,
    output logic [63:0]          cycle_cnt,
    output logic [63:0]          instr_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [6:0] TRAP_OP = 7'h6b;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            wen;
        logic [7:0]      wdest;
        logic [XLEN-1:0] wdata;
        logic            trap;
        logic [7:0]      code;
    } entry_t;

    entry_t [NCH-1:0]         lane_e;
    entry_t                   mem_q [DEPTH];
    entry_t                   head_e;

    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d, npush;
    logic [NCH-1:0]           acc;
    logic [NCH-1:0][PW-1:0]   slot;
    logic                     stop, pop;
    logic                     rdy_en_q, trap_acc_q, trap_acc_d;
    logic                     cmt_valid_q, cmt_wen_q;
    logic [XLEN-1:0]          cmt_pc_q, cmt_wdata_q;
    logic [31:0]              cmt_inst_q;
    logic [7:0]               cmt_wdest_q;
    logic                     trap_q, timeout_q;
    logic [7:0]               trap_code_q;
    logic [XLEN-1:0]          trap_pc_q;
    logic [63:0]              cycle_q, instr_q;
    logic [WW-1:0]            wdog_q, wdog_d;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        assign lane_e[g] = '{pc:    in_pc[g*XLEN +: XLEN],
                             inst:  in_inst[g*32 +: 32],
                             wen:   in_wen[g],
                             wdest: in_wdest[g*8 +: 8],
                             wdata: in_wdata[g*XLEN +: XLEN],
                             trap:  (in_inst[g*32 +: 7] == TRAP_OP),
                             code:  in_trap_code};
    end

    // rdy_en_q keeps the queue closed until the first edge after reset release
    assign in_ready = rdy_en_q && !trap_acc_q && (count_q <= CW'(DEPTH - NCH));
    assign pop      = (count_q != '0) && !trap_q;
    assign head_e   = mem_q[head_q];

    // Lane compaction; a trap lane closes the group so later lanes are dropped
    always_comb begin
        npush      = '0;
        stop       = 1'b0;
        acc        = '0;
        slot       = '0;
        trap_acc_d = trap_acc_q;
        for (int i = 0; i < NCH; i++) begin
            slot[i] = tail_q + npush[PW-1:0];
            if (in_valid[i] && in_ready && !stop) begin
                acc[i] = 1'b1;
                npush  = npush + CW'(1);
                if (lane_e[i].trap) begin
                    stop       = 1'b1;
                    trap_acc_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        tail_d  = tail_q + npush[PW-1:0];
        head_d  = head_q + PW'(pop);
        count_d = count_q + npush - CW'(pop);
        if (|acc)
            wdog_d = '0;
        else if (!trap_q && wdog_q != WW'(TIMEOUT))
            wdog_d = wdog_q + WW'(1);
        else
            wdog_d = wdog_q;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++)
            if (acc[i]) mem_q[slot[i]] <= lane_e[i];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdy_en_q    <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            trap_acc_q  <= 1'b0;
            cmt_valid_q <= 1'b0;
            cmt_pc_q    <= '0;
            cmt_inst_q  <= '0;
            cmt_wen_q   <= 1'b0;
            cmt_wdest_q <= '0;
            cmt_wdata_q <= '0;
            trap_q      <= 1'b0;
            trap_code_q <= '0;
            trap_pc_q   <= '0;
            timeout_q   <= 1'b0;
            cycle_q     <= '0;
            instr_q     <= '0;
            wdog_q      <= '0;
        end else begin
            rdy_en_q    <= 1'b1;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            trap_acc_q  <= trap_acc_d;
            cmt_valid_q <= pop;
            wdog_q      <= wdog_d;
            if (pop) begin
                cmt_pc_q    <= head_e.pc;
                cmt_inst_q  <= head_e.inst;
                cmt_wen_q   <= head_e.wen;
                cmt_wdest_q <= head_e.wdest;
                cmt_wdata_q <= head_e.wdata;
                instr_q     <= instr_q + 64'd1;
                if (head_e.trap) begin
                    trap_q      <= 1'b1;
                    trap_code_q <= head_e.code;
                    trap_pc_q   <= head_e.pc;
                end
            end
            if (!trap_q)
                cycle_q <= cycle_q + 64'd1;
            if (wdog_d == WW'(TIMEOUT))
                timeout_q <= 1'b1;
        end
    end

    assign cmt_valid = cmt_valid_q;
    assign cmt_pc    = cmt_pc_q;
    assign cmt_inst  = cmt_inst_q;
    assign cmt_wen   = cmt_wen_q;
    assign cmt_wdest = cmt_wdest_q;
    assign cmt_wdata = cmt_wdata_q;
    assign trap      = trap_q;
    assign trap_code = trap_code_q;
    assign trap_pc   = trap_pc_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

endmodule

// File: tb/tb_commit_tracker.sv
// Directed bench for commit_tracker (NCH=2, DEPTH=8, TIMEOUT=16): vector table for the
// burst/stall/gap cases plus hand sequences for wrap, reset, watchdog and traps.
module tb_commit_tracker;
    localparam int XLEN = 64, NCH = 2, DEPTH = 8, TIMEOUT = 16;
    localparam logic [63:0] WK = 64'h5A5A_0000_0000_A5A5;
    localparam logic [63:0] B  = 64'h8000_0000;

    logic                clock = 1'b0;
    logic                reset;
    logic [NCH-1:0]      in_valid, in_wen;
    logic [NCH*XLEN-1:0] in_pc, in_wdata;
    logic [NCH*32-1:0]   in_inst;
    logic [NCH*8-1:0]    in_wdest;
    logic [7:0]          in_trap_code;
    logic                in_ready, cmt_valid, cmt_wen, trap, timeout;
    logic [XLEN-1:0]     cmt_pc, cmt_wdata, trap_pc;
    logic [31:0]         cmt_inst;
    logic [7:0]          cmt_wdest, trap_code;
    logic [63:0]         cycle_cnt, instr_cnt;

    commit_tracker #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen),
        .in_wdest(in_wdest), .in_wdata(in_wdata), .in_trap_code(in_trap_code),
        .in_ready(in_ready), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
        .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata),
        .trap(trap), .trap_code(trap_code), .trap_pc(trap_pc), .timeout(timeout),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                         input logic [31:0] i0 = 32'h13, input logic [31:0] i1 = 32'h13);
        in_valid = v;
        in_pc    = {p1, p0};
        in_inst  = {i1, i0};
        in_wdata = {p1 ^ WK, p0 ^ WK};
        in_wen   = v;
        in_wdest = {8'd2, 8'd1};
    endtask

    task automatic do_reset();
        drive(2'b00, 64'h0, 64'h0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  vld;
        logic [63:0] pc0, pc1;
        logic        rdy, cv;
        logic [63:0] pc;
    } vec_t;
    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int pulses;
        tbl[0]  = '{2'b11, B+64'h00, B+64'h04, 1'b1, 1'b0, 64'h0};
        tbl[1]  = '{2'b11, B+64'h08, B+64'h0C, 1'b1, 1'b1, B+64'h00};
        tbl[2]  = '{2'b11, B+64'h10, B+64'h14, 1'b1, 1'b1, B+64'h04};
        tbl[3]  = '{2'b11, B+64'h18, B+64'h1C, 1'b1, 1'b1, B+64'h08};
        tbl[4]  = '{2'b11, B+64'h20, B+64'h24, 1'b1, 1'b1, B+64'h0C};
        tbl[5]  = '{2'b11, B+64'h28, B+64'h2C, 1'b0, 1'b1, B+64'h10};
        tbl[6]  = '{2'b11, 64'hDEAD0, 64'hDEAD4, 1'b1, 1'b1, B+64'h14};
        tbl[7]  = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b1, B+64'h18};
        tbl[8]  = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b1, B+64'h1C};
        tbl[9]  = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b1, B+64'h20};
        tbl[10] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b1, B+64'h24};
        tbl[11] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b1, B+64'h28};
        tbl[12] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b1, B+64'h2C};
        tbl[13] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b0, B+64'h2C};
        tbl[14] = '{2'b10, 64'h0, 64'h100, 1'b1, 1'b0, B+64'h2C};
        tbl[15] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 64'h100};
        tbl[16] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 64'h100};

        // reset state
        reset = 1'b1;
        in_trap_code = 8'h00;
        drive(2'b00, 64'h0, 64'h0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.cmt_valid", cmt_valid, 0);
        chk("rst.cmt_pc", cmt_pc, 0);
        chk("rst.trap", trap, 0);
        chk("rst.trap_code", trap_code, 0);
        chk("rst.trap_pc", trap_pc, 0);
        chk("rst.timeout", timeout, 0);
        chk("rst.cycle_cnt", cycle_cnt, 0);
        chk("rst.instr_cnt", instr_cnt, 0);
        reset = 1'b0;
        step();
        chk("rel.in_ready", in_ready, 1);
        chk("rel.cycle_cnt", cycle_cnt, 1);

        // burst, back-pressure, ignored group, single lane-1 gap
        for (int k = 0; k < 17; k++) begin
            drive(tbl[k].vld, tbl[k].pc0, tbl[k].pc1);
            step();
            chk($sformatf("tbl%0d.in_ready", k), in_ready, tbl[k].rdy);
            chk($sformatf("tbl%0d.cmt_valid", k), cmt_valid, tbl[k].cv);
            chk($sformatf("tbl%0d.cmt_pc", k), cmt_pc, tbl[k].pc);
            if (tbl[k].cv)
                chk($sformatf("tbl%0d.cmt_wdata", k), cmt_wdata, tbl[k].pc ^ WK);
        end
        chk("tbl.cmt_wdest", cmt_wdest, 8'd2);
        chk("tbl.cmt_wen", cmt_wen, 1);
        chk("tbl.instr_cnt", instr_cnt, 13);
        chk("tbl.cycle_cnt", cycle_cnt, 18);

        // pointer wrap with push/pop every cycle
        for (int i = 0; i < 20; i++) begin
            drive(2'b01, 64'h1000 + 64'(4*i), 64'h0);
            step();
            chk($sformatf("wrap%0d.cmt_valid", i), cmt_valid, (i > 0));
            chk($sformatf("wrap%0d.cmt_pc", i), cmt_pc, (i > 0) ? 64'h1000 + 64'(4*(i-1)) : 64'h100);
        end
        drive(2'b00, 64'h0, 64'h0);
        step();
        chk("wrap.last_valid", cmt_valid, 1);
        chk("wrap.last_pc", cmt_pc, 64'h1000 + 64'(4*19));

        // reset with 5 entries queued
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 64'h6000 + 64'(8*k), 64'h6004 + 64'(8*k));
            step();
        end
        chk("q5.cmt_valid", cmt_valid, 1);
        drive(2'b00, 64'h0, 64'h0);
        reset = 1'b1;
        #1;
        chk("midrst.cmt_valid", cmt_valid, 0);
        chk("midrst.cycle_cnt", cycle_cnt, 0);
        chk("midrst.instr_cnt", instr_cnt, 0);
        chk("midrst.in_ready", in_ready, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // idle watchdog, also shows no stale entry drains
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (cmt_valid) pulses++;
            if (k == 1)  chk("idle.in_ready", in_ready, 1);
            if (k == 15) chk("wdog15.timeout", timeout, 0);
            if (k == 16) chk("wdog16.timeout", timeout, 1);
        end
        chk("idle.stale_pulses", pulses, 0);
        chk("idle.instr_cnt", instr_cnt, 0);
        drive(2'b01, 64'h5000, 64'h0);
        step();
        drive(2'b00, 64'h0, 64'h0);
        step();
        step();
        chk("post.timeout", timeout, 1);
        chk("post.cmt_pc", cmt_pc, 64'h5000);
        chk("post.cmt_valid", cmt_valid, 0);

        // trap on lane 0, lane 1 dropped
        do_reset();
        step();
        in_trap_code = 8'h00;
        drive(2'b11, 64'h3000, 64'h3004, 32'h0000006b, 32'h13);
        step();
        chk("trA1.in_ready", in_ready, 0);
        chk("trA1.cmt_valid", cmt_valid, 0);
        chk("trA1.trap", trap, 0);
        in_trap_code = 8'h77;
        drive(2'b00, 64'h0, 64'h0);
        step();
        chk("trA2.cmt_valid", cmt_valid, 1);
        chk("trA2.cmt_pc", cmt_pc, 64'h3000);
        chk("trA2.cmt_inst", cmt_inst, 32'h6b);
        chk("trA2.trap", trap, 1);
        chk("trA2.trap_pc", trap_pc, 64'h3000);
        chk("trA2.trap_code", trap_code, 8'h00);
        chk("trA2.cycle_cnt", cycle_cnt, 3);
        chk("trA2.instr_cnt", instr_cnt, 1);
        drive(2'b11, 64'h3100, 64'h3104);
        step();
        chk("trA3.cmt_valid", cmt_valid, 0);
        chk("trA3.in_ready", in_ready, 0);
        chk("trA3.cycle_cnt", cycle_cnt, 3);
        chk("trA3.instr_cnt", instr_cnt, 1);
        step();
        chk("trA4.cmt_valid", cmt_valid, 0);
        chk("trA4.cycle_cnt", cycle_cnt, 3);
        chk("trA4.cmt_pc", cmt_pc, 64'h3000);
        chk("trA4.trap_code", trap_code, 8'h00);

        // trap on lane 1, lane 0 still commits first
        do_reset();
        step();
        in_trap_code = 8'hA5;
        drive(2'b11, 64'h4000, 64'h4004, 32'h13, 32'h1234006b);
        step();
        chk("trB1.in_ready", in_ready, 0);
        chk("trB1.cmt_valid", cmt_valid, 0);
        in_trap_code = 8'h00;
        drive(2'b00, 64'h0, 64'h0);
        step();
        chk("trB2.cmt_valid", cmt_valid, 1);
        chk("trB2.cmt_pc", cmt_pc, 64'h4000);
        chk("trB2.trap", trap, 0);
        step();
        chk("trB3.cmt_valid", cmt_valid, 1);
        chk("trB3.cmt_pc", cmt_pc, 64'h4004);
        chk("trB3.trap", trap, 1);
        chk("trB3.trap_pc", trap_pc, 64'h4004);
        chk("trB3.trap_code", trap_code, 8'hA5);
        chk("trB3.instr_cnt", instr_cnt, 2);
        chk("trB3.cycle_cnt", cycle_cnt, 4);
        step();
        chk("trB4.cmt_valid", cmt_valid, 0);
        chk("trB4.cycle_cnt", cycle_cnt, 4);
        chk("trB4.instr_cnt", instr_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
